// File: rtl/fixed_weight_sampler_pkg.sv
// ---------------------------------------------------------------------------
// pq_pkg
//   Shared types for the fixed-weight sampler.
//   fw_state_e  : sampler FSM states
//   FW_REJ_W    : width of the saturating reject counter
//   fw_sat_inc  : saturating increment for the reject counter
// ---------------------------------------------------------------------------
package pq_pkg;

    typedef enum logic [1:0] {
        FW_IDLE,
        FW_FILL,
        FW_DONE
    } fw_state_e;

    localparam int FW_REJ_W = 16;

    // Sticks at all-ones instead of wrapping, so a long run of rejects
    // never makes the counter look small again.
    function automatic logic [FW_REJ_W-1:0] fw_sat_inc(input logic [FW_REJ_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fixed_weight_sampler_if.sv
// ---------------------------------------------------------------------------
// fixed_weight_sampler_if
//   Bundles the sampler's control, random-stream and vector handshakes.
//   Signal names carry the sampler's point of view (_i into it, _o out).
//   slave  : the sampler itself
//   master : whoever drives start/weight/random stream and consumes the vector
//   start_i, weight_i, clear_i      control
//   rnd_i, rnd_valid_i, rnd_ready_o random index stream
//   vec_o, vec_valid_o, vec_ready_i result vector handshake
//   busy_o, rej_cnt_o               status
// ---------------------------------------------------------------------------
interface fixed_weight_sampler_if import pq_pkg::*; #(
    parameter int N     = 64,
    parameter int IDX_W = $clog2(N),
    parameter int WT_W  = $clog2(N + 1)
) ();

    logic                start_i;
    logic [WT_W-1:0]     weight_i;
    logic                clear_i;
    logic [IDX_W-1:0]    rnd_i;
    logic                rnd_valid_i;
    logic                rnd_ready_o;
    logic [N-1:0]        vec_o;
    logic                vec_valid_o;
    logic                vec_ready_i;
    logic                busy_o;
    logic [FW_REJ_W-1:0] rej_cnt_o;

    modport slave (
        input  start_i, weight_i, clear_i, rnd_i, rnd_valid_i, vec_ready_i,
        output rnd_ready_o, vec_o, vec_valid_o, busy_o, rej_cnt_o
    );

    modport master (
        output start_i, weight_i, clear_i, rnd_i, rnd_valid_i, vec_ready_i,
        input  rnd_ready_o, vec_o, vec_valid_o, busy_o, rej_cnt_o
    );

endinterface

// File: rtl/fixed_weight_sampler_dec.sv
// ---------------------------------------------------------------------------
// fw_idx_dec
//   Combinational index decoder: turns a random index into an N-bit one-hot
//   mask and flags whether the index addresses a real bit (idx < N).
//   idx_i      : random index sample
//   onehot_o   : one-hot mask, all zero when idx_i >= N
//   in_range_o : idx_i < N
// ---------------------------------------------------------------------------
module fw_idx_dec #(
    parameter int N     = 64,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [N-1:0]     onehot_o,
    output logic             in_range_o
);

    for (genvar i = 0; i < N; i++) begin : g_oh
        assign onehot_o[i] = (idx_i == IDX_W'(i));
    end

    // When N is a power of two every index is in range; avoid a constant compare.
    if (N == (1 << IDX_W)) begin : g_full
        assign in_range_o = 1'b1;
    end else begin : g_part
        assign in_range_o = (idx_i < IDX_W'(N));
    end

endmodule

// File: rtl/fixed_weight_sampler.sv
// ---------------------------------------------------------------------------
// fixed_weight_sampler
//   Builds an N-bit vector with exactly w ones, taking bit positions from a
//   random index stream. Indices >= N and indices already set are discarded
//   and counted as rejects.
//   clk_i  : clock
//   rst_ni : async active-low reset
//   bus    : fixed_weight_sampler_if.slave (control, rnd stream, vector, status)
// ---------------------------------------------------------------------------
module fixed_weight_sampler import pq_pkg::*; #(
    parameter int N     = 64,
    parameter int IDX_W = $clog2(N),
    parameter int WT_W  = $clog2(N + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fixed_weight_sampler_if.slave  bus
);

    fw_state_e           state_q, state_d;
    logic [N-1:0]        vec_q, vec_d;
    logic [WT_W-1:0]     cnt_q, cnt_d;
    logic [WT_W-1:0]     wt_q, wt_d;
    logic [FW_REJ_W-1:0] rej_q, rej_d;

    logic [N-1:0]        onehot;
    logic                in_range;
    logic                take, dup, hit;
    logic [WT_W-1:0]     cnt_inc, wt_clamp;

    fw_idx_dec #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx_i      (bus.rnd_i),
        .onehot_o   (onehot),
        .in_range_o (in_range)
    );

    // A sample is consumed on every valid beat while filling; it either sets
    // a fresh bit (hit) or is rejected.
    assign take     = bus.rnd_valid_i && (state_q == FW_FILL);
    assign dup      = |(onehot & vec_q);
    assign hit      = take && in_range && !dup;
    assign cnt_inc  = cnt_q + 1'b1;
    assign wt_clamp = (bus.weight_i > WT_W'(N)) ? WT_W'(N) : bus.weight_i;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        wt_d    = wt_q;
        rej_d   = rej_q;
        if (bus.clear_i) begin
            state_d = FW_IDLE;
            vec_d   = '0;
            cnt_d   = '0;
            rej_d   = '0;
        end else begin
            case (state_q)
                FW_IDLE: begin
                    if (bus.start_i) begin
                        vec_d   = '0;
                        cnt_d   = '0;
                        rej_d   = '0;
                        wt_d    = wt_clamp;
                        state_d = (wt_clamp == '0) ? FW_DONE : FW_FILL;
                    end
                end
                FW_FILL: begin
                    if (hit) begin
                        vec_d = vec_q | onehot;
                        cnt_d = cnt_inc;
                        // Leave FILL on the edge that sets the last bit so
                        // ready drops before a surplus sample can be taken.
                        if (cnt_inc == wt_q) state_d = FW_DONE;
                    end else if (take) begin
                        rej_d = fw_sat_inc(rej_q);
                    end
                end
                FW_DONE: begin
                    if (bus.vec_ready_i) state_d = FW_IDLE;
                end
                default: state_d = FW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FW_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            wt_q    <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            wt_q    <= wt_d;
            rej_q   <= rej_d;
        end
    end

    assign bus.vec_o       = vec_q;
    assign bus.vec_valid_o = (state_q == FW_DONE);
    assign bus.rnd_ready_o = (state_q == FW_FILL);
    assign bus.busy_o      = (state_q != FW_IDLE);
    assign bus.rej_cnt_o   = rej_q;

endmodule

// File: tb/tb_fixed_weight_sampler.sv
module tb_fixed_weight_sampler;
    import pq_pkg::*;

    localparam int NA = 64;
    localparam int NB = 48;

    typedef struct {
        logic [63:0] vec;
        int          rej;
        int          used;
        int          wc;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fixed_weight_sampler_if #(.N(NA)) ifa ();
    fixed_weight_sampler_if #(.N(NB)) ifb ();

    fixed_weight_sampler #(.N(NA)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    fixed_weight_sampler #(.N(NB)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    int     used_a = 0;
    int     used_b = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (ifa.rnd_valid_i && ifa.rnd_ready_o) used_a <= used_a + 1;
        if (ifb.rnd_valid_i && ifb.rnd_ready_o) used_b <= used_b + 1;
    end

    exp_t   qa[$];
    exp_t   qb[$];
    int     cur_s[$];
    int     cur_w  = 0;
    int     base_a = 0;
    int     base_b = 0;
    longint c0_a   = 0;
    longint c0_b   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the sample list in order, keep a set of chosen bits,
    // stop once w distinct in-range positions are held.
    function automatic exp_t model(input int n, input int w, input int s[$], input int lim, input int lat);
        exp_t e;
        int   cnt;
        e.vec  = '0;
        e.rej  = 0;
        e.used = 0;
        e.wc   = (w > n) ? n : w;
        e.lat  = lat;
        cnt    = 0;
        for (int i = 0; i < s.size() && i < lim && cnt < e.wc; i++) begin
            e.used++;
            if (s[i] >= n || e.vec[s[i]] == 1'b1) begin
                if (e.rej < 65535) e.rej++;
            end else begin
                e.vec[s[i]] = 1'b1;
                cnt++;
            end
        end
        return e;
    endfunction

    // Monitor A: mid-fill state against the model prefix, result on handshake.
    initial begin : mon_a
        exp_t        e;
        bit          seen;
        logic [63:0] hold;
        seen = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifa.busy_o && !ifa.vec_valid_o) begin
                    e = model(NA, cur_w, cur_s, used_a - base_a, -1);
                    chk("fill_vec", ifa.vec_o, e.vec);
                    chk("fill_rej", ifa.rej_cnt_o, e.rej);
                end
                if (ifa.vec_valid_o) begin
                    if (qa.size() == 0) begin
                        chk("unexpected_valid_a", ifa.vec_valid_o, 1'b0);
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            hold = ifa.vec_o;
                            chk("rdy_low_in_done", ifa.rnd_ready_o, 1'b0);
                            if (qa[0].lat >= 0) chk("latency_a", cyc - c0_a + 1, qa[0].lat);
                        end else begin
                            chk("hold_vec_a", ifa.vec_o, hold);
                        end
                        if (ifa.vec_ready_i) begin
                            e = qa.pop_front();
                            chk("vec_a", ifa.vec_o, e.vec);
                            chk("rej_a", ifa.rej_cnt_o, e.rej);
                            chk("ones_a", $countones(ifa.vec_o), e.wc);
                            chk("used_a", used_a - base_a, e.used);
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        bit   seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ifb.vec_valid_o) begin
                if (qb.size() == 0) begin
                    chk("unexpected_valid_b", ifb.vec_valid_o, 1'b0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (qb[0].lat >= 0) chk("latency_b", cyc - c0_b + 1, qb[0].lat);
                    end
                    if (ifb.vec_ready_i) begin
                        e = qb.pop_front();
                        chk("vec_b", ifb.vec_o, e.vec);
                        chk("rej_b", ifb.rej_cnt_o, e.rej);
                        chk("used_b", used_b - base_b, e.used);
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // abort: 0 run to completion, 1 clear_i after abort_k cycles, 2 reset after abort_k cycles
    task automatic run_a(input int w, input int s[$], input int gap, input int bp,
                         input bit pulse, input int lat, input int abort, input int abort_k);
        int p;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!ifa.busy_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("idle_wait", ifa.busy_o, 1'b0);
        cur_s = s;
        cur_w = w;
        if (abort == 0) qa.push_back(model(NA, w, s, s.size(), lat));
        ifa.vec_ready_i = (bp == 0);
        ifa.weight_i    = 7'(w);
        ifa.start_i     = 1'b1;
        base_a          = used_a;
        tick();
        ifa.start_i = 1'b0;
        c0_a        = cyc;
        ok          = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (!ifa.busy_o || ifa.vec_valid_o) begin
                ok = 1'b1;
                break;
            end
            if (abort != 0 && k == abort_k) break;
            p = used_a - base_a;
            if (p < s.size()) begin
                ifa.rnd_valid_i = ($urandom_range(99) >= gap);
                ifa.rnd_i       = 6'(s[p]);
            end else begin
                ifa.rnd_valid_i = 1'b0;
            end
            tick();
        end
        ifa.rnd_valid_i = 1'b0;
        if (abort == 1) begin
            ifa.clear_i = 1'b1;
            tick();
            ifa.clear_i = 1'b0;
            chk("clear_vec", ifa.vec_o, '0);
            chk("clear_busy", ifa.busy_o, 1'b0);
            chk("clear_rdy", ifa.rnd_ready_o, 1'b0);
            chk("clear_rej", ifa.rej_cnt_o, '0);
            return;
        end
        if (abort == 2) begin
            rst_n = 1'b0;
            #1;
            chk("arst_vec", ifa.vec_o, '0);
            chk("arst_valid", ifa.vec_valid_o, 1'b0);
            chk("arst_rdy", ifa.rnd_ready_o, 1'b0);
            chk("arst_busy", ifa.busy_o, 1'b0);
            chk("arst_rej", ifa.rej_cnt_o, '0);
            tick();
            rst_n = 1'b1;
            tick();
            return;
        end
        if (!ok) begin
            chk("fill_timeout", ifa.vec_valid_o, 1'b1);
            ifa.clear_i = 1'b1;
            tick();
            ifa.clear_i = 1'b0;
            qa.delete();
            return;
        end
        for (int i = 0; i < bp; i++) begin
            if (pulse) begin
                ifa.start_i  = ~ifa.start_i;
                ifa.weight_i = 7'd5;
            end
            tick();
        end
        ifa.vec_ready_i = 1'b1;
        ifa.start_i     = pulse;
        tick();
        ifa.start_i = 1'b0;
        chk("done_to_idle", ifa.busy_o, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int s[$];
        {ifa.start_i, ifa.clear_i, ifa.rnd_valid_i, ifa.vec_ready_i} = '0;
        {ifb.start_i, ifb.clear_i, ifb.rnd_valid_i, ifb.vec_ready_i} = '0;
        ifa.weight_i = '0;
        ifa.rnd_i    = '0;
        ifb.weight_i = '0;
        ifb.rnd_i    = '0;
        rst_n = 1'b0;
        tick();
        chk("rst_vec", ifa.vec_o, '0);
        chk("rst_valid", ifa.vec_valid_o, 1'b0);
        chk("rst_rdy", ifa.rnd_ready_o, 1'b0);
        chk("rst_busy", ifa.busy_o, 1'b0);
        chk("rst_rej", ifa.rej_cnt_o, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back, no rejects
        s = {5, 9, 63, 1, 2};
        run_a(3, s, 0, 0, 1'b0, 4, 0, 0);
        // repeated index rejected as duplicate; trailing samples must stay unconsumed
        s = {7, 7, 7, 12, 20, 21};
        run_a(2, s, 0, 0, 1'b0, 5, 0, 0);
        // zero weight goes straight to DONE
        s = {1, 2};
        run_a(0, s, 0, 0, 1'b0, 1, 0, 0);
        // backpressure with start pulsed while holding
        s.delete();
        repeat (200) s.push_back(int'($urandom_range(63)));
        run_a(4, s, 0, 10, 1'b1, -1, 0, 0);
        // clear mid-fill
        s = {3, 3, 8, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        run_a(10, s, 0, 0, 1'b0, -1, 1, 4);

        // out-of-range indices on the N=48 instance
        s = {50, 63, 3, 47, 5, 6};
        qb.push_back(model(NB, 2, s, s.size(), 5));
        ifb.vec_ready_i = 1'b1;
        ifb.weight_i    = 6'd2;
        ifb.start_i     = 1'b1;
        base_b          = used_b;
        tick();
        ifb.start_i = 1'b0;
        c0_b        = cyc;
        for (int k = 0; k < 20; k++) begin
            if (ifb.vec_valid_o) break;
            ifb.rnd_valid_i = 1'b1;
            ifb.rnd_i       = 6'(s[used_b - base_b]);
            tick();
        end
        ifb.rnd_valid_i = 1'b0;
        chk("b_reached_done", ifb.vec_valid_o, 1'b1);
        tick();
        tick();

        // full weight and clamped weight with gapped random stream
        s.delete();
        repeat (2000) s.push_back(int'($urandom_range(63)));
        run_a(64, s, 30, 0, 1'b0, -1, 0, 0);
        s.delete();
        repeat (2000) s.push_back(int'($urandom_range(63)));
        run_a(70, s, 30, 2, 1'b0, -1, 0, 0);

        for (int r = 0; r < 4; r++) begin
            s.delete();
            repeat (2000) s.push_back(int'($urandom_range(63)));
            run_a(int'($urandom_range(64, 1)), s, int'($urandom_range(50)),
                  int'($urandom_range(3)), 1'b0, -1, 0, 0);
        end

        // async reset mid-fill
        s = {4, 4, 6, 6, 8, 9, 10, 11, 12, 13, 14};
        run_a(9, s, 0, 0, 1'b0, -1, 2, 5);

        repeat (3) tick();
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
